// File: rtl/operand_read_stage_pkg.sv
// Shared types for the register-read stage: instruction bundle, held operand bundle,
// and source-field extraction helpers.
package operand_read_stage_pkg;

    localparam int INSN_ADDR_W = 32;
    localparam int OPERAND_W   = 32;
    localparam int REG_COUNT   = 32;
    localparam int FIELD_W     = 5;

    // Address is word aligned, so bits [1:0] are not carried.
    typedef struct packed {
        logic [INSN_ADDR_W-1:2] addr;
        logic [31:0]            insn;
    } InsnBundle;

    typedef struct packed {
        InsnBundle              insn;
        logic [OPERAND_W-1:0]   rs1_val;
        logic [OPERAND_W-1:0]   rs2_val;
        logic                   valid;
    } OperandBundle;

    function automatic logic [FIELD_W-1:0] rs1_idx(input logic [31:0] insn);
        return insn[19:15];
    endfunction

    function automatic logic [FIELD_W-1:0] rs2_idx(input logic [31:0] insn);
        return insn[24:20];
    endfunction

endpackage

// File: rtl/operand_read_stage_if.sv
// Decode-side and execute-side handshake bundle of the register-read stage.
interface operand_read_stage_if;
    import operand_read_stage_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    InsnBundle            in_insn;
    logic                 out_valid;
    logic                 out_ready;
    InsnBundle            out_insn;
    logic [OPERAND_W-1:0] out_rs1_val;
    logic [OPERAND_W-1:0] out_rs2_val;

    modport master (
        output in_valid, in_insn, out_ready,
        input  in_ready, out_valid, out_insn, out_rs1_val, out_rs2_val
    );

    modport slave (
        input  in_valid, in_insn, out_ready,
        output in_ready, out_valid, out_insn, out_rs1_val, out_rs2_val
    );

endinterface

// File: rtl/operand_read_stage_read_slot.sv
// One held instruction with operands; load/clear control and, with
// OPERAND_READ_BYPASS_EN defined, writeback snooping of the held operands.
module operand_read_stage_read_slot
    import operand_read_stage_pkg::*;
#(
    parameter int RIDX_W = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  OperandBundle         load_data,
    input  logic                 wb_valid,
    input  logic [RIDX_W-1:0]    wb_rd,
    input  logic [OPERAND_W-1:0] wb_data,
    output OperandBundle         q,
    output OperandBundle         fwd
);

    OperandBundle slot_r;
    OperandBundle fwd_s;
    OperandBundle next_s;

`ifdef OPERAND_READ_BYPASS_EN
    logic [FIELD_W-1:0] rs1_full_s;
    logic [FIELD_W-1:0] rs2_full_s;
    logic [RIDX_W-1:0]  rs1_s;
    logic [RIDX_W-1:0]  rs2_s;

    // Held contents with this cycle's writeback folded in (x0 never replaced).
    always_comb begin
        fwd_s      = slot_r;
        rs1_full_s = rs1_idx(slot_r.insn.insn);
        rs2_full_s = rs2_idx(slot_r.insn.insn);
        rs1_s      = rs1_full_s[RIDX_W-1:0];
        rs2_s      = rs2_full_s[RIDX_W-1:0];
        if (wb_valid && (wb_rd == rs1_s) && (rs1_s != {RIDX_W{1'b0}})) begin
            fwd_s.rs1_val = wb_data;
        end else begin
            fwd_s.rs1_val = slot_r.rs1_val;
        end
        if (wb_valid && (wb_rd == rs2_s) && (rs2_s != {RIDX_W{1'b0}})) begin
            fwd_s.rs2_val = wb_data;
        end else begin
            fwd_s.rs2_val = slot_r.rs2_val;
        end
    end
`else
    logic unused_wb_s;

    // Without bypass the held operands never change.
    always_comb begin
        fwd_s       = slot_r;
        unused_wb_s = wb_valid ^ (^wb_rd) ^ (^wb_data);
    end
`endif

    // Clear only drops valid; payload is don't-care once invalid.
    always_comb begin
        next_s = fwd_s;
        if (clear) begin
            next_s.valid = 1'b0;
        end else if (load) begin
            next_s = load_data;
        end else begin
            next_s = fwd_s;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_r <= {$bits(OperandBundle){1'b0}};
        end else begin
            slot_r <= next_s;
        end
    end

    assign q   = slot_r;
    assign fwd = fwd_s;

endmodule

// File: rtl/operand_read_stage.sv
// Register-read stage: output register O plus one skid slot S behind a valid/ready
// handshake, with flush. OPERAND_READ_BYPASS_EN enables writeback bypass/snoop.
module operand_read_stage
    import operand_read_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = INSN_ADDR_W,
    parameter int XLEN       = OPERAND_W,
    parameter int NREGS      = REG_COUNT,
    localparam int RIDX_W    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    operand_read_stage_if.slave bus,
    output logic [RIDX_W-1:0]   rf_raddr1,
    output logic [RIDX_W-1:0]   rf_raddr2,
    input  logic [XLEN-1:0]     rf_rdata1,
    input  logic [XLEN-1:0]     rf_rdata2,
    input  logic                wb_valid,
    input  logic [RIDX_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush
);

    // Bundle widths come from the package, so the parameters must agree with it.
    if ((ADDR_WIDTH != INSN_ADDR_W) || (XLEN != OPERAND_W)) begin : g_cfg_mismatch
        $error("operand_read_stage: ADDR_WIDTH/XLEN must match operand_read_stage_pkg");
    end

    logic [FIELD_W-1:0] rs1_full_s;
    logic [FIELD_W-1:0] rs2_full_s;
    logic [XLEN-1:0]    op1_s;
    logic [XLEN-1:0]    op2_s;
    OperandBundle       in_bundle_s;

    OperandBundle o_q, o_fwd_s, o_data_s;
    OperandBundle s_q, s_fwd_s;
    logic         o_load_s, o_clear_s, s_load_s, s_clear_s;
    logic         in_ready_s, accept_s, fire_s, o_free_s;

    // Register file addressing straight from the incoming instruction.
    always_comb begin
        rs1_full_s = rs1_idx(bus.in_insn.insn);
        rs2_full_s = rs2_idx(bus.in_insn.insn);
        rf_raddr1  = rs1_full_s[RIDX_W-1:0];
        rf_raddr2  = rs2_full_s[RIDX_W-1:0];
    end

    // Operand select at accept: x0 first, then writeback bypass, then register file.
    always_comb begin
        if (rf_raddr1 == {RIDX_W{1'b0}}) begin
            op1_s = {XLEN{1'b0}};
`ifdef OPERAND_READ_BYPASS_EN
        end else if (wb_valid && (wb_rd == rf_raddr1)) begin
            op1_s = wb_data;
`endif
        end else begin
            op1_s = rf_rdata1;
        end
        if (rf_raddr2 == {RIDX_W{1'b0}}) begin
            op2_s = {XLEN{1'b0}};
`ifdef OPERAND_READ_BYPASS_EN
        end else if (wb_valid && (wb_rd == rf_raddr2)) begin
            op2_s = wb_data;
`endif
        end else begin
            op2_s = rf_rdata2;
        end
        in_bundle_s.insn    = bus.in_insn;
        in_bundle_s.rs1_val = op1_s;
        in_bundle_s.rs2_val = op2_s;
        in_bundle_s.valid   = 1'b1;
    end

    // in_ready depends only on held state and reset, never on out_ready.
    assign in_ready_s = !s_q.valid && rst;
    assign fire_s     = o_q.valid && bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s && !flush;
    assign o_free_s   = !o_q.valid || fire_s;

    // Slot steering; S always drains into O before anything new reaches O.
    always_comb begin
        o_load_s  = 1'b0;
        o_clear_s = 1'b0;
        s_load_s  = 1'b0;
        s_clear_s = 1'b0;
        o_data_s  = in_bundle_s;
        if (flush) begin
            o_clear_s = 1'b1;
            s_clear_s = 1'b1;
        end else if (o_free_s) begin
            if (s_q.valid) begin
                o_load_s  = 1'b1;
                o_data_s  = s_fwd_s;
                s_clear_s = 1'b1;
            end else if (accept_s) begin
                o_load_s  = 1'b1;
                o_data_s  = in_bundle_s;
            end else begin
                o_clear_s = 1'b1;
            end
        end else begin
            if (accept_s) begin
                s_load_s = 1'b1;
            end else begin
                s_load_s = 1'b0;
            end
        end
    end

    operand_read_stage_read_slot #(.RIDX_W(RIDX_W)) u_slot_o (
        .clk       (clk),
        .rst       (rst),
        .load      (o_load_s),
        .clear     (o_clear_s),
        .load_data (o_data_s),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .q         (o_q),
        .fwd       (o_fwd_s)
    );

    operand_read_stage_read_slot #(.RIDX_W(RIDX_W)) u_slot_s (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load_s),
        .clear     (s_clear_s),
        .load_data (in_bundle_s),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .q         (s_q),
        .fwd       (s_fwd_s)
    );

    logic unused_o_fwd_s;
    assign unused_o_fwd_s = ^o_fwd_s;

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = o_q.valid;
    assign bus.out_insn    = o_q.insn;
    assign bus.out_rs1_val = o_q.rs1_val;
    assign bus.out_rs2_val = o_q.rs2_val;

endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Pipelined register-read stage with valid/ready handshake: accepts one decoded instruction per cycle, reads its two source operands from the register file, and presents instruction plus operands to execute one cycle later. Replaces the plain always-forward read register with backpressure, a one-entry skid slot, flush, and optional writeback bypass. Sits between decode and execute in the core pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 32, instruction address width (word-aligned, bits [1:0] implied zero)
- XLEN, 32, operand data width
- NREGS, 32, architectural register count; RIDX_W = $clog2(NREGS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_insn  in  stage::InsnBundle  incoming instruction (addr, insn)
- rf_raddr1, rf_raddr2  out  RIDX_W  register file read addresses (combinational from in_insn)
- rf_rdata1, rf_rdata2  in  XLEN  register file read data, same cycle as address
- wb_valid  in  1  writeback this cycle
- wb_rd  in  RIDX_W  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  downstream instruction valid
- out_ready  in  1  downstream accepts
- out_insn  out  stage::InsnBundle  registered instruction
- out_rs1_val, out_rs2_val  out  XLEN  registered operands

## Operation
- rs1 = insn[19:15], rs2 = insn[24:20] (truncated to RIDX_W); reg 0 always reads 0 regardless of rf_rdata.
- Storage: output register (O) plus skid slot (S). in_ready = !S.valid && rst.
- Accept when in_valid && in_ready && !flush. Fire-out when out_valid && out_ready.
- O empty or firing: accepted instr goes to O; if S valid, S moves to O first and accepted instr goes to S.
- O full and not firing: accepted instr goes to S; in_ready drops next cycle.
- Order strictly preserved: S never bypasses O.
- flush: O.valid, S.valid cleared next cycle; same-cycle in_valid dropped; same-cycle fire-out still counts as delivered downstream.
- Data in O and S not observed by downstream while out_valid=0; contents undefined when invalid.

## Timing
- Reset (rst=0 at clk edge): out_valid=0, S.valid=0, in_ready=0 while rst low; out_insn/out_rs*_val=0. Reset mid-transfer discards everything.
- Latency: accept at cycle N → out_valid at N+1.
- Throughput: 1/cycle with out_ready held 1; no bubble after stall release.
- Stall: out_ready=0 holds O stable (insn and operands) until fire.
- in_ready is registered-state only (no combinational path from out_ready).
- Simultaneous flush and out_ready: flush wins for everything except the instr in O, which is delivered.

## Configuration
- OPERAND_READ_BYPASS_EN defined: on accept, if wb_valid && wb_rd==rsX && rsX!=0, operand takes wb_data instead of rf_rdata; O and S snoop writeback each cycle and replace matching operands (rsX!=0) while held.
- Undefined: operands always from rf_rdata at accept; no snooping. Hazard avoidance is the scoreboard's responsibility.

## Structure
- stage package: existing InsnBundle; add OperandBundle typedef (insn, rs1_val, rs2_val, valid).
- InsnDecodePkg: rs1_idx()/rs2_idx() field-extraction functions.
- One sub-module: read_slot — single OperandBundle register with load, clear, and writeback-snoop (snoop logic under the macro); instantiated twice (O, S).

## Test plan
- Reset: hold rst=0 3 cycles with in_valid=1 → out_valid=0, in_ready=0; release → in_ready=1 next cycle.
- Streaming: 8 back-to-back instrs, out_ready=1 → 8 out_valid cycles, 1-cycle latency, operands equal rf model, order preserved.
- Backpressure: out_ready=0 for 4 cycles mid-stream → exactly 2 held, in_ready=0 after second, no loss/duplication on release.
- x0: insn with rs1=0, rf_rdata1=0xDEADBEEF → out_rs1_val=0.
- Flush: O and S full, flush=1 with in_valid=1, out_ready=0 → next cycle out_valid=0, in_ready=1, dropped instr never appears.
- Bypass (macro on): held instr rs2=5, wb_valid=1 wb_rd=5 wb_data=0x1234 while stalled → out_rs2_val=0x1234 at fire; macro off → original rf value.
